// File: rtl/genius_pkg.sv
// Shared colour codes and sequence-player states used by the game FSM,
// the sequence player and the LED driver.
package genius_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    BLUE   = 2'b01,
    RED    = 2'b10,
    YELLOW = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SHOW = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } player_state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a phase.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays the stored colour sequence: each step is lit for ON_CYCLES and then
// blanked for GAP_CYCLES; done pulses once after the last step.
module sequence_player
  import genius_pkg::*;
#(
  parameter  int MAX_LEN    = 32,
  parameter  int ON_CYCLES  = 25000000,
  parameter  int GAP_CYCLES = 12500000,
  localparam int AW         = $clog2(MAX_LEN),
  localparam int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [LW-1:0] seq_len,
  input  logic          start,
  input  logic          abort,
  output logic [1:0]    led_code,
  output logic          led_on,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  localparam int TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  player_state_t state_q, state_nx;
  logic [AW-1:0] step_q, step_nx;
  logic [LW-1:0] len_q, len_nx, len_clamp;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  color_t        mem [MAX_LEN];
  color_t        led_code_q, rd_code;
  logic          led_on_q, busy_q, done_q, wr_fire;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Writes are only taken while not playing, so the active sequence is stable.
  assign wr_fire   = wr_en && (state_q == IDLE || state_q == DONE)
                     && (32'(wr_addr) < MAX_LEN);
  assign len_clamp = (seq_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : seq_len;
  // Forward a same-cycle write so a start alongside a write shows the new colour.
  assign rd_code   = (wr_fire && wr_addr == step_nx) ? color_t'(wr_data) : mem[step_nx];

  // Sequence memory, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= GREEN;
    end else if (wr_fire) begin
      mem[wr_addr] <= color_t'(wr_data);
    end
  end

  // Next-state logic: abort overrides every transition, including start in IDLE.
  always_comb begin
    state_nx = state_q;
    step_nx  = step_q;
    len_nx   = len_q;
    tmr_load = 1'b0;
    tmr_val  = TW'(ON_CYCLES - 1);
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          len_nx  = len_clamp;
          step_nx = '0;
          if (len_clamp == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = SHOW;
            tmr_load = 1'b1;
          end
        end
      end
      SHOW: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (tmr_zero) begin
          state_nx = GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (tmr_zero) begin
          if (LW'(step_q) + LW'(1) == len_q) begin
            state_nx = DONE;
          end else begin
            state_nx = SHOW;
            step_nx  = step_q + AW'(1);
            tmr_load = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, step bookkeeping and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      len_q      <= '0;
      led_code_q <= GREEN;
      led_on_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      step_q   <= step_nx;
      len_q    <= len_nx;
      led_on_q <= (state_nx == SHOW);
      busy_q   <= (state_nx == SHOW) || (state_nx == GAP);
      done_q   <= (state_nx == DONE);
      if (state_nx == SHOW) led_code_q <= rd_code;
    end
  end

  assign led_code = led_code_q;
  assign led_on   = led_on_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON_CYCLES=4, GAP_CYCLES=2, MAX_LEN=8.
module tb_sequence_player;

  localparam int MAX_LEN = 8;
  localparam int ONC     = 4;
  localparam int GAPC    = 2;
  localparam int STEP    = ONC + GAPC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic [3:0] seq_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] led_code;
  logic       led_on, busy, done;
  logic [2:0] step_idx;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_mem [MAX_LEN];
  int show_cnt;

  sequence_player #(
    .MAX_LEN(MAX_LEN), .ON_CYCLES(ONC), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seq_len(seq_len), .start(start), .abort(abort),
    .led_code(led_code), .led_on(led_on), .busy(busy),
    .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input int addr, input int data);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 2'(data);
    tick();
    wr_en = 1'b0;
  endtask

  // Start a playback of len effective steps and check every cycle up to
  // two cycles past done; inject_k > 0 drives start and a write at that cycle.
  task automatic run_seq(input string name, input int len, input int inject_k);
    int last;
    int stp;
    logic e_on, e_busy, e_done, prev_on;
    last = len * STEP;
    show_cnt = 0;
    prev_on = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= last + 2; k++) begin
      stp    = (k - 1) / STEP;
      e_busy = (k <= last);
      e_done = (k == last + 1);
      e_on   = e_busy && (((k - 1) % STEP) < ONC);
      chk($sformatf("%s_on_c%0d", name, k), 32'(led_on), 32'(e_on));
      chk($sformatf("%s_busy_c%0d", name, k), 32'(busy), 32'(e_busy));
      chk($sformatf("%s_done_c%0d", name, k), 32'(done), 32'(e_done));
      if (e_busy) begin
        chk($sformatf("%s_code_c%0d", name, k), 32'(led_code), 32'(exp_mem[stp]));
        chk($sformatf("%s_step_c%0d", name, k), 32'(step_idx), 32'(stp));
      end
      if (led_on && !prev_on) show_cnt++;
      prev_on = led_on;
      if (k == inject_k) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 2'b10;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_led_on", 32'(led_on), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_step", 32'(step_idx), 0);
    chk("rst_code", 32'(led_code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Normal playback of 00,11,01
    for (int i = 0; i < MAX_LEN; i++) exp_mem[i] = 2'b00;
    write_mem(0, 0); write_mem(1, 3); write_mem(2, 1);
    exp_mem[0] = 2'b00; exp_mem[1] = 2'b11; exp_mem[2] = 2'b01;
    seq_len = 4'd3;
    run_seq("norm", 3, 0);
    chk("norm_shows", 32'(show_cnt), 3);

    // Zero length
    seq_len = 4'd0;
    run_seq("zero", 0, 0);

    // Start and write while busy are ignored
    seq_len = 4'd3;
    run_seq("intf", 3, 3);
    run_seq("intf_replay", 3, 0);

    // Abort during step 1 SHOW
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    chk("abort_pre_on", 32'(led_on), 1);
    chk("abort_pre_code", 32'(led_code), 32'(exp_mem[1]));
    chk("abort_pre_step", 32'(step_idx), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_on", 32'(led_on), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("abort_idle_done_c%0d", k), 32'(done), 0);
      chk($sformatf("abort_idle_busy_c%0d", k), 32'(busy), 0);
      tick();
    end
    run_seq("abort_replay", 3, 0);

    // Abort in IDLE beats start
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_on", 32'(led_on), 0);
    tick();
    chk("idle_abort_busy2", 32'(busy), 0);
    chk("idle_abort_done2", 32'(done), 0);

    // Clamp: seq_len 12 plays all 8 steps
    write_mem(3, 2); write_mem(4, 3); write_mem(5, 0); write_mem(6, 1); write_mem(7, 2);
    exp_mem[3] = 2'b10; exp_mem[4] = 2'b11; exp_mem[5] = 2'b00;
    exp_mem[6] = 2'b01; exp_mem[7] = 2'b10;
    seq_len = 4'd12;
    run_seq("clamp", 8, 0);
    chk("clamp_shows", 32'(show_cnt), 8);
    chk("clamp_last_step", 32'(step_idx), 7);

    // Async reset mid-SHOW, between edges
    seq_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("arst_pre_on", 32'(led_on), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_on", 32'(led_on), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_step", 32'(step_idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle_busy", 32'(busy), 0);
    for (int i = 0; i < MAX_LEN; i++) exp_mem[i] = 2'b00;
    seq_len = 4'd8;
    run_seq("arst_mem", 8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
